fetch_queue: RTL and testbench

- Instruction-fetch front end of the RSA-decryption ASIP.
- Sits directly upstream of the 5-stage `path` datapath and drives its `instruction` input.
- Generates sequential fetch addresses, issues in-order requests to instruction memory (variable latency), and buffers returned words in a small FIFO.
- Supports pipeline stall and branch flush/redirect.

---
 rtl/fetch_queue.sv | 119 +++++++++++
 tb/tb_fetch_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with credit-limited, in-order memory requests and an output FIFO.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the output when the FIFO is empty.
module fetch_queue #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] flush_pc,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ready,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] instruction,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid
);
    localparam int unsigned     AW      = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
    localparam logic [AW+1:0]   CAP     = (AW+2)'(DEPTH);

    logic [WIDTH-1:0] fetch_pc;
    logic [AW:0]      count, outstanding, drop, out_next;
    logic [AW-1:0]    rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [WIDTH-1:0] tag_mem  [DEPTH];

    logic [AW+1:0]    credit_used;
    logic             accept, keep, push, pop, bypass;
    logic [WIDTH-1:0] rsp_pc;

    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign mem_req     = reset & ~flush & (credit_used < CAP);
    assign mem_addr    = fetch_pc;
    assign accept      = mem_req & mem_ready;
    // Stale responses are always the oldest in flight, so drop==0 means this one is live.
    assign keep        = mem_rvalid & (drop == '0) & ~flush;
    assign rsp_pc      = tag_mem[tag_rd];

`ifdef FETCH_BYPASS_EN
    assign bypass = reset & keep & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push = keep & ~(bypass & ~stall);
    assign pop  = (count != '0) & ~stall & ~flush;

    always_comb begin
        out_next = outstanding;
        if (accept && !mem_rvalid) out_next = outstanding + CNT_ONE;
        else if (!accept && mem_rvalid) out_next = outstanding - CNT_ONE;
    end

    always_comb begin
        instr_valid = 1'b0;
        instruction = '0;
        instr_pc    = '0;
        if (count != '0) begin
            instr_valid = 1'b1;
            instruction = data_mem[rd_ptr];
            instr_pc    = pc_mem[rd_ptr];
        end else if (bypass) begin
            instr_valid = 1'b1;
            instruction = mem_rdata;
            instr_pc    = rsp_pc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            outstanding <= out_next;
            if (flush) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= flush_pc;
                count    <= '0;
                drop     <= out_next;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                tag_rd   <= '0;
                tag_wr   <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + WIDTH'(4);
                    tag_wr   <= tag_wr + PTR_ONE;
                end
                if (mem_rvalid && drop != '0) drop <= drop - CNT_ONE;
                if (keep) tag_rd <= tag_rd + PTR_ONE;
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                if (push && !pop) count <= count + CNT_ONE;
                else if (pop && !push) count <= count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
        if (accept) tag_mem[tag_wr] <= fetch_pc;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    localparam int          W   = 32;
    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic         clock = 1'b0;
    logic         reset, stall, flush, mem_req, mem_ready, mem_rvalid, instr_valid;
    logic [W-1:0] flush_pc, mem_addr, mem_rdata, instruction, instr_pc;

    fetch_queue #(.WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] pc; bit stale; int due; } req_t;

    req_t        inflight[$];
    logic [31:0] fifo[$];
    logic [31:0] obs_pc[$];
    logic [31:0] obs_word[$];
    logic [31:0] model_pc;
    logic [31:0] prog [5] = '{32'h00088000, 32'h01100029, 32'h02190002, 32'h0320002B, 32'h45300020};
    int          cyc, checks, errors, lat, jitter, dut_accepts;
    logic        last_valid, last_rv;
    logic [31:0] last_ins, last_ipc;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr < 32'h14) return prog[addr[4:2]];
        return {addr[15:0] ^ 16'h5A5A, addr[31:16] ^ addr[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic st, input logic fl, input logic [31:0] fpc, input logic rdy);
        logic        rv, hit, pop, exp_req, exp_valid;
        logic [31:0] exp_ins, exp_ipc;
        req_t        h, n;
        stall = st; flush = fl; flush_pc = fpc; mem_ready = rdy;
        rv = reset && inflight.size() > 0 && cyc >= inflight[0].due;
        mem_rvalid = rv;
        mem_rdata  = rv ? mem_word(inflight[0].pc) : $urandom;
        #3;
        exp_req = reset && !fl && (fifo.size() + inflight.size() < D);
        hit = 1'b0;
`ifdef FETCH_BYPASS_EN
        hit = reset && rv && !inflight[0].stale && !fl && fifo.size() == 0;
`endif
        if (hit) begin
            exp_valid = 1'b1; exp_ipc = inflight[0].pc; exp_ins = mem_word(inflight[0].pc);
        end else if (fifo.size() > 0) begin
            exp_valid = 1'b1; exp_ipc = fifo[0]; exp_ins = mem_word(fifo[0]);
        end else begin
            exp_valid = 1'b0; exp_ipc = '0; exp_ins = '0;
        end
        chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
        chk("mem_addr", mem_addr, model_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
        chk("instruction", instruction, exp_ins);
        chk("instr_pc", instr_pc, exp_ipc);
        last_valid = instr_valid; last_ins = instruction; last_ipc = instr_pc; last_rv = rv;
        if (mem_req && rdy) dut_accepts++;
        if (instr_valid && !st && !fl) begin
            obs_pc.push_back(instr_pc);
            obs_word.push_back(instruction);
        end
        pop = exp_valid && !st && !fl;
        if (rv) begin
            h = inflight.pop_front();
            if (!h.stale && !fl && !(hit && pop)) fifo.push_back(h.pc);
        end
        if (pop && !hit) void'(fifo.pop_front());
        if (exp_req && rdy) begin
            n.pc = model_pc; n.stale = 1'b0;
            n.due = cyc + lat + (jitter != 0 ? int'($urandom_range(0, 2)) : 0);
            inflight.push_back(n);
            model_pc = model_pc + 32'd4;
        end
        if (fl && reset) begin
            fifo.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            model_pc = fpc;
        end
        @(posedge clock); #1;
        cyc++;
    endtask

    task automatic reset_now();
        stall = 1'b0; flush = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; reset = 1'b0;
        #1;
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        fifo.delete(); inflight.delete(); model_pc = RPC;
        cycle(0, 0, 0, 0);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] fp;
        checks = 0; errors = 0; cyc = 0; lat = 1; jitter = 0; dut_accepts = 0;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; model_pc = RPC;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        reset = 1'b1;

        // Basic fetch, one-cycle memory.
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1);
        chk("basic_count", {31'b0, obs_pc.size() >= 5}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("basic_pc", obs_pc[i], 32'(i * 4));
            chk("basic_word", obs_word[i], prog[i]);
        end

        // Back-pressure from a fresh start.
        reset_now();
        dut_accepts = 0;
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1);
        chk("bp_requests", 32'(dut_accepts), 32'd4);
        chk("bp_req_off", {31'b0, mem_req}, 32'd0);
        chk("bp_valid", {31'b0, instr_valid}, 32'd1);
        obs_pc.delete(); obs_word.delete();
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) chk("bp_order", obs_pc[i], 32'(i * 4));

        // Flush with two requests in flight, latency 3.
        reset_now();
        lat = 3;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        obs_pc.delete(); obs_word.delete();
        cycle(0, 1, 32'h100, 1);
        for (int i = 0; i < 14; i++) cycle(0, 0, 0, 1);
        chk("flush_first_pc", obs_pc[0], 32'h100);
        chk("flush_first_word", obs_word[0], mem_word(32'h100));
        chk("flush_second_pc", obs_pc[1], 32'h104);

        // Flush together with a response, ready, and stall.
        lat = 1;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
        obs_pc.delete(); obs_word.delete();
        cycle(1, 1, 32'h200, 1);
        chk("sim_empty", {31'b0, instr_valid}, 32'd0);
        chk("sim_addr", mem_addr, 32'h200);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
        chk("sim_first_pc", obs_pc[0], 32'h200);

        // Reset asserted with three words buffered.
        for (int i = 0; i < 10 && fifo.size() != 3; i++) cycle(1, 0, 0, 1);
        chk("rstmid_valid_before", {31'b0, instr_valid}, 32'd1);
        reset_now();
        obs_pc.delete(); obs_word.delete();
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
        chk("rstmid_restart_pc", obs_pc[0], RPC);

        // Response into an empty FIFO.
        cycle(0, 1, 32'h10, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("bypass_rv", {31'b0, last_rv}, 32'd1);
`ifdef FETCH_BYPASS_EN
        chk("bypass_same_valid", {31'b0, last_valid}, 32'd1);
        chk("bypass_same_word", last_ins, 32'h45300020);
`else
        chk("bypass_same_valid", {31'b0, last_valid}, 32'd0);
        cycle(0, 0, 0, 1);
        chk("bypass_late_valid", {31'b0, last_valid}, 32'd1);
        chk("bypass_late_word", last_ins, 32'h45300020);
        chk("bypass_late_pc", last_ipc, 32'h10);
`endif

        // Randomized traffic with jittered latency, flushes near the address wrap.
        jitter = 1;
        for (int i = 0; i < 500; i++) begin
            if (i == 250) lat = 2;
            fp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, fp, $urandom_range(0, 9) < 7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
